// File: rtl/imem_fetch_sequencer_pkg.sv
// Shared definitions for the instruction fetch sequencer: state encoding,
// default widths, PC register index and latency counter width.
package imem_fetch_sequencer_pkg;

  localparam int         ADDR_W_DEF    = 16;
  localparam int         DATA_W_DEF    = 32;
  localparam logic [3:0] PC_REG_ID_DEF = 4'hF;
  localparam int         LAT_CNT_W     = 2;

  localparam logic [2:0] ENC_IDLE     = 3'd0;
  localparam logic [2:0] ENC_LOAD     = 3'd1;
  localparam logic [2:0] ENC_PC_RD    = 3'd2;
  localparam logic [2:0] ENC_PC_WAIT  = 3'd3;
  localparam logic [2:0] ENC_MEM_RD   = 3'd4;
  localparam logic [2:0] ENC_MEM_WAIT = 3'd5;
  localparam logic [2:0] ENC_PC_WB    = 3'd6;
  localparam logic [2:0] ENC_HOLD     = 3'd7;

  typedef enum logic [2:0] {
    ST_IDLE     = ENC_IDLE,
    ST_LOAD     = ENC_LOAD,
    ST_PC_RD    = ENC_PC_RD,
    ST_PC_WAIT  = ENC_PC_WAIT,
    ST_MEM_RD   = ENC_MEM_RD,
    ST_MEM_WAIT = ENC_MEM_WAIT,
    ST_PC_WB    = ENC_PC_WB,
    ST_HOLD     = ENC_HOLD
  } state_t;

endpackage

// File: rtl/imem_fetch_sequencer_lat_counter.sv
// Loadable down-counter used to time register-file and memory read latency.
// o_done is high while the count sits at zero, i.e. on the last wait cycle.
module fetch_lat_counter
  import imem_fetch_sequencer_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 i_load,
  input  logic [LAT_CNT_W-1:0] i_load_val,
  output logic                 o_done
);

  logic [LAT_CNT_W-1:0] r_cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign o_done = (r_cnt == '0);

endmodule

// File: rtl/imem_fetch_sequencer.sv
// Fetch sequencer: reads the PC register, fetches the instruction, writes
// PC+1 back and presents the instruction; also services loader writes.
module imem_fetch_sequencer
  import imem_fetch_sequencer_pkg::*;
#(
  parameter logic [3:0] PC_REG_ID = PC_REG_ID_DEF,
  parameter int         REG_LAT   = 1,
  parameter int         MEM_LAT   = 1,
  parameter int         ADDR_W    = ADDR_W_DEF,
  parameter int         DATA_W    = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cs,
  input  logic              load_req,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [DATA_W-1:0] load_data,
  output logic              load_ack,
  output logic [ADDR_W-1:0] mem_address,
  output logic              mem_rd,
  output logic              mem_wn,
  output logic [DATA_W-1:0] mem_write_data,
  input  logic [DATA_W-1:0] mem_read_data,
  output logic [3:0]        reg_id,
  output logic              reg_rd,
  output logic              reg_wn,
  output logic [ADDR_W-1:0] reg_write_data,
  input  logic [ADDR_W-1:0] reg_read_data,
  output logic [DATA_W-1:0] instr,
  output logic [ADDR_W-1:0] instr_pc,
  output logic              instr_valid,
  input  logic              instr_ready,
  output logic              busy
);

  state_t               r_state;
  state_t               w_next;
  logic [ADDR_W-1:0]    r_pc;
  logic [ADDR_W-1:0]    w_pc_next;
  logic                 w_cnt_load;
  logic [LAT_CNT_W-1:0] w_cnt_val;
  logic                 w_lat_done;

  fetch_lat_counter u_lat_counter (
    .clk        (clk),
    .reset      (reset),
    .i_load     (w_cnt_load),
    .i_load_val (w_cnt_val),
    .o_done     (w_lat_done)
  );

  // Output handshake: instr_valid is high for the whole HOLD state with
  // instr/instr_pc frozen; a transfer happens on a rising edge where
  // instr_valid && instr_ready, after which instr_valid drops.
  always_comb begin
    w_next     = r_state;
    w_cnt_load = 1'b0;
    w_cnt_val  = '0;
    case (r_state)
      ST_IDLE: begin
        if (load_req) begin
          w_next = ST_LOAD;
        end else if (cs) begin
          w_next = ST_PC_RD;
        end
      end
      ST_LOAD:  w_next = ST_IDLE;
      ST_PC_RD: begin
        w_next     = ST_PC_WAIT;
        w_cnt_load = 1'b1;
        w_cnt_val  = LAT_CNT_W'(REG_LAT - 1);
      end
      ST_PC_WAIT: begin
        if (w_lat_done) w_next = ST_MEM_RD;
      end
      ST_MEM_RD: begin
        w_next     = ST_MEM_WAIT;
        w_cnt_load = 1'b1;
        w_cnt_val  = LAT_CNT_W'(MEM_LAT - 1);
      end
      ST_MEM_WAIT: begin
        if (w_lat_done) w_next = ST_PC_WB;
      end
      ST_PC_WB: w_next = ST_HOLD;
      ST_HOLD: begin
        if (instr_ready) w_next = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  // The PC is captured on the same edge that enters MEM_RD, so the read
  // address must come from the value being captured, not the old register.
  assign w_pc_next = (r_state == ST_PC_WAIT && w_lat_done) ? reg_read_data : r_pc;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state        <= ST_IDLE;
      r_pc           <= '0;
      load_ack       <= 1'b0;
      mem_address    <= '0;
      mem_rd         <= 1'b0;
      mem_wn         <= 1'b0;
      mem_write_data <= '0;
      reg_id         <= '0;
      reg_rd         <= 1'b0;
      reg_wn         <= 1'b0;
      reg_write_data <= '0;
      instr          <= '0;
      instr_pc       <= '0;
      instr_valid    <= 1'b0;
    end else begin
      r_state        <= w_next;
      r_pc           <= w_pc_next;
      load_ack       <= (w_next == ST_LOAD);
      mem_wn         <= (w_next == ST_LOAD);
      mem_rd         <= (w_next == ST_MEM_RD);
      reg_rd         <= (w_next == ST_PC_RD);
      reg_wn         <= (w_next == ST_PC_WB);
      reg_id         <= (w_next == ST_PC_RD || w_next == ST_PC_WB) ? PC_REG_ID : 4'h0;
      mem_write_data <= (w_next == ST_LOAD) ? load_data : '0;
      reg_write_data <= (w_next == ST_PC_WB) ? r_pc + ADDR_W'(1) : '0;
      instr_valid    <= (w_next == ST_HOLD);
      case (w_next)
        ST_LOAD:   mem_address <= load_addr;
        ST_MEM_RD: mem_address <= w_pc_next;
        default:   mem_address <= '0;
      endcase
      if (r_state == ST_MEM_WAIT && w_lat_done) begin
        instr    <= mem_read_data;
        instr_pc <= r_pc;
      end
    end
  end

  assign busy = (r_state != ST_IDLE);

endmodule

// File: tb/tb_imem_fetch_sequencer.sv
// Directed bench for imem_fetch_sequencer with a behavioural register file
// and instruction memory responding to the strobes with one-cycle latency.
module tb_imem_fetch_sequencer;

  logic        clk;
  logic        reset;
  logic        cs;
  logic        load_req;
  logic [15:0] load_addr;
  logic [31:0] load_data;
  logic        load_ack;
  logic [15:0] mem_address;
  logic        mem_rd;
  logic        mem_wn;
  logic [31:0] mem_write_data;
  logic [31:0] mem_read_data;
  logic [3:0]  reg_id;
  logic        reg_rd;
  logic        reg_wn;
  logic [15:0] reg_write_data;
  logic [15:0] reg_read_data;
  logic [31:0] instr;
  logic [15:0] instr_pc;
  logic        instr_valid;
  logic        instr_ready;
  logic        busy;

  logic        pc_set;
  logic [15:0] pc_set_val;
  logic [15:0] rf_pc = 16'h0;
  logic [31:0] mem [16];

  int total = 0;
  int bad   = 0;

  logic [122:0] w_all;
  assign w_all = {load_ack, mem_address, mem_rd, mem_wn, mem_write_data, reg_id,
                  reg_rd, reg_wn, reg_write_data, instr, instr_pc, instr_valid, busy};

  imem_fetch_sequencer dut (
    .clk            (clk),
    .reset          (reset),
    .cs             (cs),
    .load_req       (load_req),
    .load_addr      (load_addr),
    .load_data      (load_data),
    .load_ack       (load_ack),
    .mem_address    (mem_address),
    .mem_rd         (mem_rd),
    .mem_wn         (mem_wn),
    .mem_write_data (mem_write_data),
    .mem_read_data  (mem_read_data),
    .reg_id         (reg_id),
    .reg_rd         (reg_rd),
    .reg_wn         (reg_wn),
    .reg_write_data (reg_write_data),
    .reg_read_data  (reg_read_data),
    .instr          (instr),
    .instr_pc       (instr_pc),
    .instr_valid    (instr_valid),
    .instr_ready    (instr_ready),
    .busy           (busy)
  );

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  // register file and memory responders
  always @(posedge clk) begin
    if (mem_wn) mem[mem_address[3:0]] <= mem_write_data;
    if (mem_rd) mem_read_data <= mem[mem_address[3:0]];
    if (reg_rd) reg_read_data <= rf_pc;
    if (pc_set) rf_pc <= pc_set_val;
    else if (reg_wn && reg_id == 4'hF) rf_pc <= reg_write_data;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_pc(input logic [15:0] v);
    pc_set     = 1'b1;
    pc_set_val = v;
    tick();
    pc_set     = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (2) tick();
    total++;
    if (w_all !== '0) begin
      bad++;
      $display("FAIL reset_outputs: got %h want 0", w_all);
    end
    total++;
    if (busy !== 1'b0) begin
      bad++;
      $display("FAIL reset_busy: got %b want 0", busy);
    end
    reset = 1'b1;
    tick();
  endtask

  task automatic test_load();
    logic [15:0] addrs [5] = '{16'h0, 16'h1, 16'h2, 16'h3, 16'hFFFF};
    logic [31:0] datas [5] = '{32'h0, 32'h1, 32'h10, 32'h6, 32'hCAFEF00D};
    int n;
    for (int i = 0; i < 5; i++) begin
      load_req  = 1'b1;
      load_addr = addrs[i];
      load_data = datas[i];
      n = 0;
      do begin
        tick();
        n++;
      end while (!load_ack && n < 10);
      total++;
      if (n !== ((i == 0) ? 1 : 2)) begin
        bad++;
        $display("FAIL load_spacing[%0d]: got %0d cycles want %0d", i, n, (i == 0) ? 1 : 2);
      end
      total++;
      if (!(load_ack && mem_wn && mem_address == addrs[i] && mem_write_data == datas[i] &&
            !reg_rd && !reg_wn && !mem_rd)) begin
        bad++;
        $display("FAIL load_write[%0d]: got ack=%b wn=%b addr=%h data=%h want 1 1 %h %h",
                 i, load_ack, mem_wn, mem_address, mem_write_data, addrs[i], datas[i]);
      end
      load_req = 1'b0;
    end
    tick();
    total++;
    if (load_ack !== 1'b0 || mem_wn !== 1'b0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL load_idle: got ack=%b wn=%b busy=%b want 0 0 0", load_ack, mem_wn, busy);
    end
  endtask

  task automatic test_seq_fetch();
    logic [31:0] exp_i [4] = '{32'h0, 32'h1, 32'h10, 32'h6};
    int n;
    int wb_cnt;
    set_pc(16'h0);
    cs          = 1'b1;
    instr_ready = 1'b1;
    wb_cnt      = 0;
    for (int k = 0; k < 4; k++) begin
      n = 0;
      do begin
        tick();
        n++;
        total++;
        if ($countones({mem_rd, mem_wn, reg_rd, reg_wn}) > 1) begin
          bad++;
          $display("FAIL strobe_mutex: got %b want onehot0", {mem_rd, mem_wn, reg_rd, reg_wn});
        end
        if (reg_wn) begin
          total++;
          if (reg_write_data !== 16'(wb_cnt + 1)) begin
            bad++;
            $display("FAIL seq_writeback: got %h want %h", reg_write_data, 16'(wb_cnt + 1));
          end
          wb_cnt++;
        end
      end while (!instr_valid && n < 20);
      total++;
      if (n !== ((k == 0) ? 6 : 7)) begin
        bad++;
        $display("FAIL seq_latency[%0d]: got %0d want %0d", k, n, (k == 0) ? 6 : 7);
      end
      total++;
      if (instr !== exp_i[k] || instr_pc !== 16'(k)) begin
        bad++;
        $display("FAIL seq_instr[%0d]: got %h/%h want %h/%h", k, instr, instr_pc, exp_i[k], 16'(k));
      end
    end
    cs = 1'b0;
    repeat (2) tick();
    total++;
    if (wb_cnt !== 4 || rf_pc !== 16'h4 || busy !== 1'b0) begin
      bad++;
      $display("FAIL seq_end: got wb=%0d pc=%h busy=%b want 4 0004 0", wb_cnt, rf_pc, busy);
    end
  endtask

  task automatic test_backpressure();
    int n;
    set_pc(16'h1);
    cs          = 1'b1;
    instr_ready = 1'b0;
    n = 0;
    do begin
      tick();
      n++;
      if (n == 2) cs = 1'b0;
    end while (!instr_valid && n < 20);
    total++;
    if (n !== 6 || instr !== 32'h1 || instr_pc !== 16'h1) begin
      bad++;
      $display("FAIL bp_first: got n=%0d %h/%h want 6 00000001/0001", n, instr, instr_pc);
    end
    for (int t = 0; t < 10; t++) begin
      tick();
      total++;
      if (!(instr_valid && instr == 32'h1 && instr_pc == 16'h1 &&
            !mem_rd && !mem_wn && !reg_rd && !reg_wn)) begin
        bad++;
        $display("FAIL bp_hold[%0d]: got v=%b %h strobes=%b want 1 00000001 0000",
                 t, instr_valid, instr, {mem_rd, mem_wn, reg_rd, reg_wn});
      end
    end
    instr_ready = 1'b1;
    tick();
    total++;
    if (instr_valid !== 1'b0) begin
      bad++;
      $display("FAIL bp_release: got %b want 0", instr_valid);
    end
    for (int t = 0; t < 4; t++) begin
      tick();
      total++;
      if (busy !== 1'b0 || reg_rd !== 1'b0) begin
        bad++;
        $display("FAIL bp_no_refetch[%0d]: got busy=%b rd=%b want 0 0", t, busy, reg_rd);
      end
    end
    total++;
    if (rf_pc !== 16'h2) begin
      bad++;
      $display("FAIL bp_pc: got %h want 0002", rf_pc);
    end
  endtask

  task automatic test_pc_wrap();
    int n;
    logic seen_rd;
    logic seen_wb;
    set_pc(16'hFFFF);
    cs          = 1'b1;
    instr_ready = 1'b1;
    seen_rd     = 1'b0;
    seen_wb     = 1'b0;
    n = 0;
    do begin
      tick();
      n++;
      if (mem_rd) begin
        seen_rd = 1'b1;
        total++;
        if (mem_address !== 16'hFFFF) begin
          bad++;
          $display("FAIL wrap_addr: got %h want ffff", mem_address);
        end
      end
      if (reg_wn) begin
        seen_wb = 1'b1;
        total++;
        if (reg_write_data !== 16'h0000) begin
          bad++;
          $display("FAIL wrap_wb: got %h want 0000", reg_write_data);
        end
      end
    end while (!instr_valid && n < 20);
    cs = 1'b0;
    total++;
    if (!(seen_rd && seen_wb && instr == 32'hCAFEF00D && instr_pc == 16'hFFFF)) begin
      bad++;
      $display("FAIL wrap_instr: got rd=%b wb=%b %h/%h want 1 1 cafef00d/ffff",
               seen_rd, seen_wb, instr, instr_pc);
    end
    repeat (2) tick();
    total++;
    if (rf_pc !== 16'h0) begin
      bad++;
      $display("FAIL wrap_pc: got %h want 0000", rf_pc);
    end
  endtask

  task automatic test_arbitration();
    int n;
    int ack_at;
    int rd_at;
    logic wn_early;
    set_pc(16'h3);
    cs          = 1'b1;
    instr_ready = 1'b1;
    n = 0;
    do begin
      tick();
      n++;
    end while (!mem_rd && n < 20);
    total++;
    if (mem_rd !== 1'b1) begin
      bad++;
      $display("FAIL arb_mem_rd: got %b want 1", mem_rd);
    end
    tick();
    load_req  = 1'b1;
    load_addr = 16'h4;
    load_data = 32'h55;
    wn_early  = 1'b0;
    n = 0;
    do begin
      tick();
      n++;
      if (mem_wn) wn_early = 1'b1;
    end while (!instr_valid && n < 20);
    total++;
    if (wn_early !== 1'b0 || instr !== 32'h6 || instr_pc !== 16'h3) begin
      bad++;
      $display("FAIL arb_fetch: got wn=%b %h/%h want 0 00000006/0003", wn_early, instr, instr_pc);
    end
    ack_at = -1;
    rd_at  = -1;
    for (int t = 1; t <= 4; t++) begin
      tick();
      if (load_ack && ack_at < 0) begin
        ack_at = t;
        total++;
        if (!(mem_wn && mem_address == 16'h4 && mem_write_data == 32'h55)) begin
          bad++;
          $display("FAIL arb_write: got wn=%b %h/%h want 1 0004/00000055",
                   mem_wn, mem_address, mem_write_data);
        end
        load_req = 1'b0;
      end
      if (reg_rd && rd_at < 0) rd_at = t;
    end
    total++;
    if (ack_at !== 2 || rd_at !== 4) begin
      bad++;
      $display("FAIL arb_order: got ack@%0d rd@%0d want 2 4", ack_at, rd_at);
    end
    cs = 1'b0;
    n = 0;
    do begin
      tick();
      n++;
    end while (!instr_valid && n < 20);
    total++;
    if (instr !== 32'h55 || instr_pc !== 16'h4) begin
      bad++;
      $display("FAIL arb_next: got %h/%h want 00000055/0004", instr, instr_pc);
    end
    repeat (2) tick();
  endtask

  task automatic test_reset_mid_fetch();
    int n;
    set_pc(16'h2);
    cs          = 1'b1;
    instr_ready = 1'b1;
    repeat (2) tick();
    reset = 1'b0;
    #1;
    total++;
    if (w_all !== '0) begin
      bad++;
      $display("FAIL rst_async: got %h want 0", w_all);
    end
    for (int t = 0; t < 2; t++) begin
      tick();
      total++;
      if (w_all !== '0 || busy !== 1'b0) begin
        bad++;
        $display("FAIL rst_hold[%0d]: got %h want 0", t, w_all);
      end
    end
    total++;
    if (rf_pc !== 16'h2) begin
      bad++;
      $display("FAIL rst_no_wb: got %h want 0002", rf_pc);
    end
    reset = 1'b1;
    n = 0;
    do begin
      tick();
      n++;
    end while (!instr_valid && n < 20);
    total++;
    if (n !== 6 || instr !== 32'h10 || instr_pc !== 16'h2) begin
      bad++;
      $display("FAIL rst_restart: got n=%0d %h/%h want 6 00000010/0002", n, instr, instr_pc);
    end
    cs = 1'b0;
    repeat (2) tick();
  endtask

  initial begin
    cs          = 1'b0;
    load_req    = 1'b0;
    load_addr   = '0;
    load_data   = '0;
    instr_ready = 1'b0;
    pc_set      = 1'b0;
    pc_set_val  = '0;
    test_reset();
    test_load();
    test_seq_fetch();
    test_backpressure();
    test_pc_wrap();
    test_arbitration();
    test_reset_mid_fetch();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
